hex_display_ctrl: RTL and testbench
===================================

Name: hex_display_ctrl

Overview:
- Multi-digit seven-segment driver for the board HEX displays.
- Captures a packed hex value on a load strobe and decodes every nibble into active-low segment codes.
- Supports global enable, leading-zero blanking, and a counter-driven blink mode.
- Sits between datapath results (RAM/FIFO read data, counters) and the HEX output pins; all outputs are registered.

Parameters:
- NUM_DIGITS, 4, number of 7-seg digits driven; data width = 4*NUM_DIGITS; legal range 1..8.
- BLINK_DIV, 25_000_000, clock cycles per blink half-period; must be >= 2.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  input  4*NUM_DIGITS  packed hex value; digit i = data_in[4i+3:4i], digit 0 = least significant.
- load  input  1  capture strobe; data_in sampled on a rising edge where load=1.
- enable  input  1  1 = display on; 0 = all digits blank.
- lz_blank  input  1  1 = suppress leading zeros.
- blink  input  1  1 = flash the whole display at the BLINK_DIV rate.
- hex  output  7*NUM_DIGITS  active-low segments; digit i = hex[7i+6:7i], bit order {g,f,e,d,c,b,a}.

Behaviour:
- Reset (reset=0, asynchronous): data_reg=0, blink_cnt=0, phase=0, hex = all ones (every digit 7'b1111111). Outputs go blank immediately, without waiting for clk. Reset mid-operation discards the captured value. The first edge after release behaves as a normal cycle.
- Capture: on an edge with load=1, data_reg <= data_in. With load=0, data_reg holds. data_reg updates even when enable=0.
- Latency: hex reflects data_reg, enable, lz_blank and phase one cycle after they change.
  - load asserted at edge k gives new hex at edge k+1.
  - Back-to-back loads: each value appears for exactly one cycle, in order.
- Decode, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - blank=1111111
- Leading-zero blanking (lz_blank=1):
  - Digit i is blank iff i>0 and digits i..NUM_DIGITS-1 of data_reg are all zero.
  - Digit 0 is never suppressed, so value 0 displays a single "0".
  - Interior zeros (e.g. 0x1005) are always shown.
- Blink counter: runs only while blink=1.
  - blink_cnt counts 0..BLINK_DIV-1. On the edge where it equals BLINK_DIV-1 it wraps to 0 and phase toggles.
  - blink=0 clears blink_cnt=0 and phase=0 synchronously, so the display is visible as soon as blink drops.
  - Display is blanked when blink=1 and phase=1.
- Priority, per digit: enable=0 → blank; else blink blank → blank; else leading-zero blank → blank; else decoded nibble.
- Simultaneous events are independent:
  - load and a phase toggle on the same edge both take effect.
  - The next hex shows the new data combined with the new phase.
- Widths: blink_cnt width = $clog2(BLINK_DIV). No arithmetic on data; no overflow cases.

Test Plan (NUM_DIGITS=4, BLINK_DIV=4 for simulation):
- Reset and capture: hold reset=0 with data_in=16'h1234 and load=1 → hex all 1s. Release reset, enable=1, lz_blank=0, blink=0. Edge 1 captures the value; after edge 2, hex = {1111001, 0100100, 0110000, 0011001} for digits 3..0.
- Full decode: load 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF on consecutive cycles → each value's 16 digit codes appear one cycle after its load, in order. Every table entry is exercised.
- Leading zeros: with lz_blank=1:
  - load 16'h0000 → digits 3..1 blank, digit 0 = 1000000.
  - load 16'h00A0 → digits 3,2 blank, digit1 = 0001000, digit0 = 1000000.
  - load 16'h1005 → all four digits shown.
- Enable gating: enable=0 then load 16'hBEEF → hex all 1s. Raise enable=1 → next cycle shows b,E,E,F.
- Blink: blink=1 with data 16'h0007 → hex alternates 4 cycles visible / 4 cycles blank. Drop blink during a blank phase → visible on the next edge, and blink_cnt is 0.
- Async reset mid-blink: assert reset=0 between edges while visible → hex all 1s within the same cycle. After release, data_reg=0, so the display shows "0000" (or "0" with lz_blank=1).

Source files
------------

// File: rtl/hex_display_ctrl_if.sv
// Bundles the HEX display controller's data and control inputs with its segment output.
// The producer side drives value and control; the controller drives the segment pins.
interface hex_display_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 4
) ();
    logic [4*NUM_DIGITS-1:0] data_in;
    logic                    load;
    logic                    enable;
    logic                    lz_blank;
    logic                    blink;
    logic [7*NUM_DIGITS-1:0] hex;

    modport master (
        output data_in,
        output load,
        output enable,
        output lz_blank,
        output blink,
        input  hex
    );

    modport slave (
        input  data_in,
        input  load,
        input  enable,
        input  lz_blank,
        input  blink,
        output hex
    );
endinterface

// File: rtl/hex_display_ctrl.sv
// Multi-digit seven-segment driver: captures a packed hex value and drives active-low segments.
// Supports global enable, leading-zero blanking and counter-driven blinking; hex is registered.
module hex_display_ctrl #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned BLINK_DIV  = 25_000_000
) (
    input logic                 clk,
    input logic                 reset,
    hex_display_ctrl_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [4*NUM_DIGITS-1:0] data_reg;
    logic [CNT_W-1:0]        blink_cnt;
    logic                    phase;
    logic [7*NUM_DIGITS-1:0] hex_reg;
    logic [7*NUM_DIGITS-1:0] hex_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Walk from the most significant digit down, tracking whether everything so far was zero.
    always_comb begin
        logic       lead_zero;
        logic [3:0] nib;
        hex_next  = '1;
        lead_zero = 1'b1;
        nib       = 4'h0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            nib       = data_reg[4*i +: 4];
            lead_zero = lead_zero && (nib == 4'h0);
            if (!bus.enable || (bus.blink && phase)) begin
                hex_next[7*i +: 7] = SEG_BLANK;
            end else if (bus.lz_blank && lead_zero && (i > 0)) begin
                hex_next[7*i +: 7] = SEG_BLANK;
            end else begin
                hex_next[7*i +: 7] = seg_decode(nib);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_reg  <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
            hex_reg   <= '1;
        end else begin
            if (bus.load) begin
                data_reg <= bus.data_in;
            end
            if (!bus.blink) begin
                blink_cnt <= '0;
                phase     <= 1'b0;
            end else if (blink_cnt == CNT_MAX) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
            hex_reg <= hex_next;
        end
    end

    assign bus.hex = hex_reg;
endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl (4 digits, blink half-period of 4 cycles).
module tb_hex_display_ctrl;
    localparam logic [6:0] BL = 7'h7F;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    hex_display_ctrl_if #(.NUM_DIGITS(4)) bus ();

    hex_display_ctrl #(
        .NUM_DIGITS(4),
        .BLINK_DIV (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        load;
        logic        enable;
        logic        lz_blank;
        logic [27:0] exp_hex;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: hex=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [27:0] vis;
        logic [27:0] exp;
        checks = 0;
        errors = 0;

        // Expected output after the edge that the vector's inputs are applied before.
        vecs[0]  = '{16'h1234, 1'b1, 1'b1, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[1]  = '{16'h0123, 1'b1, 1'b1, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
        vecs[2]  = '{16'h4567, 1'b1, 1'b1, 1'b0, {7'h40, 7'h79, 7'h24, 7'h30}};
        vecs[3]  = '{16'h89AB, 1'b1, 1'b1, 1'b0, {7'h19, 7'h12, 7'h02, 7'h78}};
        vecs[4]  = '{16'hCDEF, 1'b1, 1'b1, 1'b0, {7'h00, 7'h10, 7'h08, 7'h03}};
        vecs[5]  = '{16'h0000, 1'b1, 1'b1, 1'b1, {7'h46, 7'h21, 7'h06, 7'h0E}};
        vecs[6]  = '{16'h00A0, 1'b1, 1'b1, 1'b1, {BL, BL, BL, 7'h40}};
        vecs[7]  = '{16'h1005, 1'b1, 1'b1, 1'b1, {BL, BL, 7'h08, 7'h40}};
        vecs[8]  = '{16'hFFFF, 1'b0, 1'b1, 1'b1, {7'h79, 7'h40, 7'h40, 7'h12}};
        vecs[9]  = '{16'hBEEF, 1'b1, 1'b0, 1'b0, {BL, BL, BL, BL}};
        vecs[10] = '{16'h0000, 1'b0, 1'b0, 1'b0, {BL, BL, BL, BL}};
        vecs[11] = '{16'h0000, 1'b0, 1'b1, 1'b0, {7'h03, 7'h06, 7'h06, 7'h0E}};
        vecs[12] = '{16'h0007, 1'b1, 1'b1, 1'b1, {7'h03, 7'h06, 7'h06, 7'h0E}};
        vecs[13] = '{16'h0000, 1'b0, 1'b1, 1'b1, {BL, BL, BL, 7'h78}};

        // Reset held with a load pending: outputs stay blank.
        reset        = 1'b1;
        bus.data_in  = 16'h1234;
        bus.load     = 1'b1;
        bus.enable   = 1'b1;
        bus.lz_blank = 1'b0;
        bus.blink    = 1'b0;
        #1 reset = 1'b0;
        #1 check("reset_async", bus.hex, '1);
        tick();
        tick();
        check("reset_held", bus.hex, '1);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            bus.data_in  = vecs[i].data;
            bus.load     = vecs[i].load;
            bus.enable   = vecs[i].enable;
            bus.lz_blank = vecs[i].lz_blank;
            tick();
            check($sformatf("vec%0d", i), bus.hex, vecs[i].exp_hex);
        end

        // Blink over data 0x0007 with lz_blank: 4 visible, 4 blank; reload 9 on the toggle edge.
        bus.blink = 1'b1;
        vis = {BL, BL, BL, 7'h78};
        for (int k = 1; k <= 13; k++) begin
            if (k == 8) begin
                bus.data_in = 16'h0009;
                bus.load    = 1'b1;
            end
            tick();
            bus.load = 1'b0;
            if (k == 9) vis = {BL, BL, BL, 7'h10};
            exp = (((k - 1) / 4) % 2 == 0) ? vis : '1;
            check($sformatf("blink_k%0d", k), bus.hex, exp);
        end

        // Edge 13 was blank; dropping blink shows the digit on the very next edge.
        bus.blink = 1'b0;
        tick();
        check("blink_drop", bus.hex, vis);

        // Counter restarts from zero: again 4 visible then blank.
        bus.blink = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("reblink_k%0d", k), bus.hex, (k <= 4) ? vis : '1);
        end

        // Async reset mid-blink while visible: blank before any clock edge.
        bus.blink = 1'b0;
        tick();
        check("pre_reset_visible", bus.hex, vis);
        #2 reset = 1'b0;
        #1 check("reset_mid", bus.hex, '1);
        #1 reset = 1'b1;
        tick();
        check("post_reset_lz", bus.hex, {BL, BL, BL, 7'h40});
        bus.lz_blank = 1'b0;
        tick();
        check("post_reset_zeros", bus.hex, {7'h40, 7'h40, 7'h40, 7'h40});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
